dram_cache_array_responder: RTL
===============================

Name: dram_cache_array_responder

Overview:
- Memory-controller-side responder for the DRAM cache lookup path.
- Accepts AR requests (ID + set index) from the DRAM cache controller and looks up a register-based tag/data array.
- Returns the stored 56-bit tag and 72-bit data line in order on the R channel that the controller's tag-compare stage consumes.
- Also provides a fill/update port so the controller can install lines on misses and writes.

Parameters:
- ID_WIDTH, 16, AR request ID width.
- INDEX_WIDTH, 4, set index width; array depth = 2**INDEX_WIDTH.
- DATA_WIDTH, 72, data line width (64 data + 8 ECC/meta).
- TAG_WIDTH, 56, stored tag width.
- READ_LATENCY, 3, cycles from AR acceptance to earliest rvalid_o (min 1).
- RESP_DEPTH, 4, outstanding-request limit and response buffer depth (power of 2, >= 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- arid_i  in  ID_WIDTH  request ID
- araddr_i  in  INDEX_WIDTH  set index
- arvalid_i  in  1  request valid
- arready_o  out  1  request ready
- rdata_o  out  DATA_WIDTH  returned data line
- rtag_o  out  TAG_WIDTH  returned tag
- rid_o  out  ID_WIDTH  ID of the request being answered
- rvalid_o  out  1  response valid
- rready_i  in  1  response ready
- wvalid_i  in  1  fill/update strobe, always accepted
- windex_i  in  INDEX_WIDTH  fill index
- wtag_i  in  TAG_WIDTH  fill tag
- wdata_i  in  DATA_WIDTH  fill data

Behaviour:
- Reset:
  - One clock domain; asynchronous active-low reset on rst_n, released synchronously to clk by the system.
  - Every array entry is cleared to tag 0 and data 0.
  - The pipeline is emptied, the response buffer is emptied, and the credit counter is cleared.
  - Output values during and after reset: arready_o=1, rvalid_o=0, rdata_o=0, rtag_o=0, rid_o=0.
- Credit counter:
  - outstanding = requests accepted but not yet popped from the response buffer. Range 0..RESP_DEPTH, width clog2(RESP_DEPTH)+1.
  - arready_o = (outstanding < RESP_DEPTH). It is registered-state derived only, with no combinational path from rready_i.
  - Accept = arvalid_i & arready_o. Pop = rvalid_o & rready_i.
  - Accept and pop in the same cycle leave the counter unchanged.
- Lookup:
  - On accept at edge N, stage 1 captures {arid_i, array[araddr_i].tag, array[araddr_i].data}.
  - The array value used is the one before edge N (read-before-write).
  - The capture then shifts through READ_LATENCY-1 further valid-tagged registers. The pipeline never stalls.
  - The last stage pushes into the response FIFO. Credits guarantee that no overflow occurs.
- Response:
  - rvalid_o = FIFO not empty. rdata_o, rtag_o and rid_o come from the FIFO head.
  - Outputs hold stable while rvalid_o & !rready_i.
  - Responses are strictly in acceptance order.
  - Earliest rvalid_o is high in the cycle after edge N+READ_LATENCY-1, i.e. READ_LATENCY cycles after accept.
  - No bypass: a FIFO push and pop in the same cycle are both honored.
- Fill:
  - On wvalid_i at edge M, array[windex_i] <= {wtag_i, wdata_i}.
  - A request accepted at edge M sees the old entry. A request accepted at M+1 or later sees the new entry.
  - Requests already in flight are unaffected.
- Boundaries:
  - Buffer full: arready_o=0 until a pop.
  - When the counter reaches RESP_DEPTH and a pop occurs, arready_o rises in the next cycle.
  - FIFO pointers wrap modulo RESP_DEPTH.
  - An arvalid_i that is held while arready_o=0 is not lost: it is accepted when arready_o rises.
  - An assertion fires if the FIFO pushes while full or pops while empty.

Decomposition:
- Shared package (dram_cache_pkg):
  - width constants (ID 16, INDEX 4, DATA 72, TAG 56);
  - packed struct resp_t {id, tag, data};
  - packed struct entry_t {tag, data}.
- Sub-module: the generic FIFO already used on the controller's tag path is reused as the response buffer, with DATA_WIDTH = width of resp_t and FIFO_SIZE = RESP_DEPTH. Its almost-full/almost-empty outputs are left unused.
- The pipeline and the array stay inline.

Test Plan:
- Reset then single read: fill idx 5 with tag 0xAB_CDEF, data 0x1234. Then AR id 0x7, idx 5 accepted at cycle 10, rready_i=1. Required: rvalid_o rises at cycle 13 with rtag_o=0xAB_CDEF, rdata_o=0x1234, rid_o=0x7, held for exactly 1 cycle.
- Unfilled entry: AR idx 3 after reset. Required: rtag_o=0 and rdata_o=0.
- Backpressure: rready_i=0 with 6 back-to-back ARs (ids 1..6). Required: exactly 4 accepted; arready_o=0 from the cycle after the 4th accept; responses 1..4 held stable. Then raise rready_i: ids 1..6 return in order, and id 5 is accepted the cycle after the first pop.
- Collision: fill idx 2 (tag 0x22) and AR idx 2 in the same cycle, then AR idx 2 in the next cycle. Required: first response has the old tag (0), second has tag 0x22.
- Streaming: arvalid_i held high for 20 cycles with rready_i=1 and indices 0..15 wrapping. Required: arready_o stays high throughout, throughput is 1 response/cycle, and ordering and data are correct.
- Mid-operation reset: rst_n=0 with 3 requests in flight. Required: rvalid_o=0 immediately (asynchronous); after release arready_o=1, array reads return 0, and no stale responses appear.

Source files
------------

// File: rtl/dram_cache_pkg.sv
// Shared widths and record types for the DRAM cache lookup path.
package dram_cache_pkg;

    localparam int ID_W    = 16;
    localparam int INDEX_W = 4;
    localparam int DATA_W  = 72;
    localparam int TAG_W   = 56;

    // One response as carried through the lookup pipeline and response buffer.
    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } resp_t;

    // One stored line of the tag/data array.
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/dram_cache_array_responder_fifo.sv
// Generic synchronous FIFO; head word is visible combinationally on rd_data.
module dram_cache_array_responder_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_SIZE  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int AW = $clog2(FIFO_SIZE);

    logic [DATA_WIDTH-1:0] mem [FIFO_SIZE];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr, rd_ptr;
    logic [AW:0] count;

    // Storage and pointer update; push and pop in the same cycle both take effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_SIZE; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign count        = wr_ptr - rd_ptr;
    assign full         = (count == (AW+1)'(FIFO_SIZE));
    assign empty        = (count == '0);
    assign almost_full  = (count >= (AW+1)'(FIFO_SIZE - 1));
    assign almost_empty = (count <= (AW+1)'(1));
    assign rd_data      = mem[rd_ptr[AW-1:0]];

    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(rd_en && empty));

endmodule

// File: rtl/dram_cache_array_responder.sv
// Register-array tag/data lookup with fixed-latency pipeline, credit flow control
// and an in-order response buffer.
module dram_cache_array_responder
    import dram_cache_pkg::*;
#(
    parameter int ID_WIDTH     = ID_W,
    parameter int INDEX_WIDTH  = INDEX_W,
    parameter int DATA_WIDTH   = DATA_W,
    parameter int TAG_WIDTH    = TAG_W,
    parameter int READ_LATENCY = 3,
    parameter int RESP_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ID_WIDTH-1:0]    arid_i,
    input  logic [INDEX_WIDTH-1:0] araddr_i,
    input  logic                   arvalid_i,
    output logic                   arready_o,
    output logic [DATA_WIDTH-1:0]  rdata_o,
    output logic [TAG_WIDTH-1:0]   rtag_o,
    output logic [ID_WIDTH-1:0]    rid_o,
    output logic                   rvalid_o,
    input  logic                   rready_i,
    input  logic                   wvalid_i,
    input  logic [INDEX_WIDTH-1:0] windex_i,
    input  logic [TAG_WIDTH-1:0]   wtag_i,
    input  logic [DATA_WIDTH-1:0]  wdata_i
);

    localparam int DEPTH = 2 ** INDEX_WIDTH;
    localparam int CW    = $clog2(RESP_DEPTH) + 1;

    entry_t        arr [DEPTH];
    resp_t         lookup;
    resp_t         push_data;
    resp_t         head;
    logic          push;
    logic          accept;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full_unused;
    logic          fifo_afull_unused;
    logic          fifo_aempty_unused;
    logic [CW-1:0] credit_q;

    assign arready_o = (credit_q < CW'(RESP_DEPTH));
    assign accept    = arvalid_i & arready_o;
    assign pop       = rvalid_o & rready_i;

    // Outstanding-request counter: accepted but not yet popped from the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   credit_q <= credit_q + 1'b1;
                2'b01:   credit_q <= credit_q - 1'b1;
                default: credit_q <= credit_q;
            endcase
        end
    end

    // Tag/data array; a fill lands at the edge, so a same-edge lookup sees the old line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) arr[i] <= '0;
        end else if (wvalid_i) begin
            arr[windex_i] <= '{tag: wtag_i, data: wdata_i};
        end
    end

    // Combinational read of the addressed line, paired with the request ID.
    always_comb begin
        lookup      = '0;
        lookup.id   = arid_i;
        lookup.tag  = arr[araddr_i].tag;
        lookup.data = arr[araddr_i].data;
    end

    // The buffer write is the final latency stage, so only READ_LATENCY-1 flops precede it.
    generate
        if (READ_LATENCY > 1) begin : g_pipe
            logic  [READ_LATENCY-1:1] vld_pipe;
            resp_t [READ_LATENCY-1:1] pipe;

            // Non-stalling shift of valid-tagged lookup results.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_pipe <= '0;
                    pipe     <= '0;
                end else begin
                    vld_pipe[1] <= accept;
                    pipe[1]     <= lookup;
                    for (int i = 2; i < READ_LATENCY; i++) begin
                        vld_pipe[i] <= vld_pipe[i-1];
                        pipe[i]     <= pipe[i-1];
                    end
                end
            end

            assign push      = vld_pipe[READ_LATENCY-1];
            assign push_data = pipe[READ_LATENCY-1];
        end else begin : g_nopipe
            assign push      = accept;
            assign push_data = lookup;
        end
    endgenerate

    dram_cache_array_responder_fifo #(
        .DATA_WIDTH ($bits(resp_t)),
        .FIFO_SIZE  (RESP_DEPTH)
    ) u_resp_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (push),
        .wr_data      (push_data),
        .rd_en        (pop),
        .rd_data      (head),
        .full         (fifo_full_unused),
        .empty        (fifo_empty),
        .almost_full  (fifo_afull_unused),
        .almost_empty (fifo_aempty_unused)
    );

    assign rvalid_o = ~fifo_empty;
    assign rid_o    = head.id;
    assign rtag_o   = head.tag;
    assign rdata_o  = head.data;

endmodule
